// File: rtl/seq_divider_8.sv
// Multi-cycle 8-bit restoring divider, one quotient bit per clock, unsigned or signed.
// Signed operands are divided as magnitudes and the signs are restored at the end.
module seq_divider_8 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       signed_mode,
    input  logic [7:0] dividend,
    input  logic [7:0] divisor,
    output logic       busy,
    output logic       done,
    output logic [7:0] quotient,
    output logic [7:0] remainder,
    output logic       div_by_zero,
    output logic       overflow
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t     r_state;
    logic [8:0] r_acc;
    logic [7:0] r_q;
    logic [7:0] r_dvs;
    logic [7:0] r_dvd_raw;
    logic [2:0] r_count;
    logic       r_q_neg;
    logic       r_r_neg;
    logic       r_zero;
    logic       r_ovf;

    logic [7:0] w_dvd_mag;
    logic [7:0] w_dvs_mag;
    logic [8:0] w_acc_sh;
    logic [9:0] w_trial;
    logic       w_no_borrow;

    // Operand magnitudes; |8'h80| is 128, which the unsigned datapath handles directly.
    always_comb begin
        w_dvd_mag = dividend;
        w_dvs_mag = divisor;
        if (signed_mode && dividend[7]) begin
            w_dvd_mag = 8'd0 - dividend;
        end else begin
            w_dvd_mag = dividend;
        end
        if (signed_mode && divisor[7]) begin
            w_dvs_mag = 8'd0 - divisor;
        end else begin
            w_dvs_mag = divisor;
        end
    end

    // One restoring step: shift in the next dividend bit, trial-subtract; carry out means no borrow.
    always_comb begin
        w_acc_sh    = {r_acc[7:0], r_q[7]};
        w_trial     = {1'b0, w_acc_sh} + {1'b0, ~{1'b0, r_dvs}} + 10'd1;
        w_no_borrow = w_trial[9];
    end

    // Control FSM with registered result and handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_acc       <= 9'd0;
            r_q         <= 8'd0;
            r_dvs       <= 8'd0;
            r_dvd_raw   <= 8'd0;
            r_count     <= 3'd0;
            r_q_neg     <= 1'b0;
            r_r_neg     <= 1'b0;
            r_zero      <= 1'b0;
            r_ovf       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= 8'd0;
            remainder   <= 8'd0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy      <= 1'b1;
                        r_dvd_raw <= dividend;
                        if (divisor == 8'd0) begin
                            r_zero  <= 1'b1;
                            r_state <= S_FIX;
                        end else begin
                            r_zero      <= 1'b0;
                            r_q         <= w_dvd_mag;
                            r_dvs       <= w_dvs_mag;
                            r_q_neg     <= signed_mode & (dividend[7] ^ divisor[7]);
                            r_r_neg     <= signed_mode & dividend[7];
                            r_ovf       <= signed_mode && (dividend == 8'h80) && (divisor == 8'hFF);
                            r_acc       <= 9'd0;
                            r_count     <= 3'd7;
                            div_by_zero <= 1'b0;
                            overflow    <= 1'b0;
                            r_state     <= S_CALC;
                        end
                    end else begin
                        busy <= 1'b0;
                    end
                end
                S_CALC: begin
                    if (w_no_borrow) begin
                        r_acc <= w_trial[8:0];
                    end else begin
                        r_acc <= w_acc_sh;
                    end
                    r_q     <= {r_q[6:0], w_no_borrow};
                    r_count <= r_count - 3'd1;
                    if (r_count == 3'd0) begin
                        r_state <= S_FIX;
                    end else begin
                        r_state <= S_CALC;
                    end
                end
                S_FIX: begin
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    r_state <= S_IDLE;
                    if (r_zero) begin
                        quotient    <= 8'hFF;
                        remainder   <= r_dvd_raw;
                        div_by_zero <= 1'b1;
                        overflow    <= 1'b0;
                    end else begin
                        quotient    <= r_q_neg ? (8'd0 - r_q) : r_q;
                        remainder   <= r_r_neg ? (8'd0 - r_acc[7:0]) : r_acc[7:0];
                        div_by_zero <= 1'b0;
                        overflow    <= r_ovf;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/seq_divider_8.md
# seq_divider_8

Multi-cycle 8-bit integer divider for the arithmetic section, the inverse-operation partner of the combinational add/subtract unit. It performs restoring division, one quotient bit per clock, using a 9-bit trial subtraction (a + ~b + 1) each step. It supports unsigned and two's-complement signed operands and reports divide-by-zero and signed overflow. A start/done handshake lets a controller issue one division at a time.

## Interface
- No parameters; width fixed at 8 bits.
- clk  input  1  rising-edge clock; the only clock
- rst_n  input  1  reset, synchronous, active-low
- start  input  1  request; sampled only when busy=0
- signed_mode  input  1  0 = unsigned, 1 = two's-complement signed; sampled with start
- dividend  input  8  numerator; sampled with start
- divisor  input  8  denominator; sampled with start
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse; result valid
- quotient  output  8  result; holds until the next accepted start
- remainder  output  8  result; holds until the next accepted start
- div_by_zero  output  1  flag valid with done; holds
- overflow  output  1  signed −128 / −1 flag, valid with done; holds

## Operation
- States: IDLE, CALC, FIX.
- IDLE, start=1, divisor≠0:
  - latch the magnitudes |dividend| and |divisor|; magnitudes apply in signed mode only, raw values otherwise
  - latch the sign of quotient (dividend[7]^divisor[7]) and the sign of remainder (dividend[7]); both are 0 in unsigned mode
  - clear acc (9 bit); set count=7; go to CALC
  - clear div_by_zero and overflow
- IDLE, start=1, divisor=0: go to FIX with a zero-divide marker.
- CALC step:
  - shift {acc, q} left by one, bringing in the next dividend MSB
  - trial = acc − divisor, computed as acc + ~{0,divisor} + 1
  - if the trial does not borrow: acc = trial and the new q bit = 1; otherwise acc is kept and the q bit = 0
  - decrement count; after the step taken at count=0, go to FIX
- FIX:
  - quotient = q, negated if the quotient sign is set
  - remainder = acc[7:0], negated if the remainder sign is set
  - pulse done; go to IDLE
- Zero divide (in FIX): quotient=8'hFF, remainder=dividend, div_by_zero=1.
- Signed overflow: dividend=8'h80, divisor=8'hFF, signed_mode=1.
  - quotient=8'h80 (the natural 8-bit wrap), remainder=8'h00, overflow=1
  - normal latency
- Signed results truncate toward zero; a nonzero remainder takes the sign of the dividend.
- −128 magnitude: |8'h80| = 128 fits the unsigned 8-bit path and must not be treated as an error.
- start while busy=1 is ignored: inputs are not re-sampled and the state is unaffected.
- Reset mid-operation aborts immediately to IDLE with all outputs at their reset values. No result is produced.

## Timing
- Reset values: busy=0, done=0, quotient=8'h00, remainder=8'h00, div_by_zero=0, overflow=0. State is IDLE.
- Clock edges are numbered from the edge that samples start (E0).
- Normal division:
  - CALC steps occur at E1–E8 and FIX at E9
  - busy is high from E0 to E9, i.e. 9 cycles
  - done is high for the single cycle after E9; outputs update at E9
- Zero divide:
  - FIX occurs at E1
  - busy is high for 1 cycle; done is high for the cycle after E1
- During the done cycle the block is already in IDLE with busy=0. A start in that cycle is accepted, giving back-to-back operation with no idle gap.
- Result outputs change only at FIX and at reset.

## Test plan
- Unsigned: signed_mode=0, 200/7.
  - quotient=28, remainder=4, flags 0
  - done exactly 10 cycles after the start edge (E0 … pulse after E9); busy high 9 cycles
- Signed: signed_mode=1, −100/7 (8'h9C/8'h07).
  - quotient=8'hF2 (−14), remainder=8'hFE (−2)
  - also check 100/−7: quotient=8'hF2, remainder=8'h02
- Zero divide: 50/0 in either mode.
  - quotient=8'hFF, remainder=50, div_by_zero=1
  - done on the cycle after E1
  - the next valid division clears div_by_zero
- Signed overflow: signed_mode=1, 8'h80/8'hFF.
  - quotient=8'h80, remainder=0, overflow=1
  - same case with signed_mode=0: 128/255 gives quotient=0, remainder=128, overflow=0
- Handshake:
  - a start with different operands pulsed at E4 of a running 200/7 is ignored; the result stays 28 r 4
  - a start asserted during the done cycle is accepted, and its result arrives 10 cycles later
- Reset: rst_n=0 at E5 of a division.
  - the next cycle shows busy=0, done=0, all outputs 0
  - no done pulse follows, and a fresh start works normally
